// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ARM-style condition codes and NZCV flag bit positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: decides whether an instruction executes
// given its condition field and the architectural NZCV flags.
module cond_check
  import cpu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  cond_t cond_code;
  logic  n, z, c, v;

  assign cond_code = cond_t'(cond);
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_ex = 1'b0;
    case (cond_code)
      COND_EQ: cond_ex = z;
      COND_NE: cond_ex = ~z;
      COND_CS: cond_ex = c;
      COND_CC: cond_ex = ~c;
      COND_MI: cond_ex = n;
      COND_PL: cond_ex = ~n;
      COND_VS: cond_ex = v;
      COND_VC: cond_ex = ~v;
      COND_HI: cond_ex = c & ~z;
      COND_LS: cond_ex = ~c | z;
      COND_GE: cond_ex = (n == v);
      COND_LT: cond_ex = (n != v);
      COND_GT: cond_ex = ~z & (n == v);
      COND_LE: cond_ex = z | (n != v);
      COND_AL: cond_ex = 1'b1;
      COND_NV: cond_ex = 1'b1;
      default: cond_ex = 1'b1;
    endcase
  end

endmodule

// File: rtl/execute_cond_em.sv
// Execute-stage back half: NZCV flags register, conditional-execution squash,
// and the execute-to-memory pipeline register (falling-edge, like the other stages).
module execute_cond_em
  import cpu_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            CLK,
  input  logic            CLR,
  input  logic            PCSrcE,
  input  logic            RegWriteE,
  input  logic            MemToRegE,
  input  logic            MemWriteE,
  input  logic            BranchE,
  input  logic [1:0]      FlagWriteE,
  input  logic [3:0]      CondE,
  input  logic [3:0]      ALUFlags,
  input  logic [SIZE-1:0] ALUResultE,
  input  logic [SIZE-1:0] WriteDataE,
  input  logic [4:0]      WA3E,
  input  logic [6:0]      CtrlE,
  output logic            CondExE,
  output logic            PCSrcGatedE,
  output logic [3:0]      FlagsE,
  output logic            PCSrcM,
  output logic            RegWriteM,
  output logic            MemToRegM,
  output logic            MemWriteM,
  output logic [SIZE-1:0] ALUResultM,
  output logic [SIZE-1:0] WriteDataM,
  output logic [4:0]      WA3M,
  output logic [6:0]      CtrlM
);

  logic write_nz;
  logic write_cv;

  // The condition is tested against the registered flags, so an instruction
  // that also writes flags still sees the previous values.
  cond_check u_cond_check (
    .cond    (CondE),
    .flags   (FlagsE),
    .cond_ex (CondExE)
  );

  assign PCSrcGatedE = (PCSrcE | BranchE) & CondExE;
  assign write_nz    = FlagWriteE[1] & CondExE;
  assign write_cv    = FlagWriteE[0] & CondExE;

  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      FlagsE <= 4'b0000;
    end else begin
      if (write_nz) begin
        FlagsE[FLAG_N] <= ALUFlags[FLAG_N];
        FlagsE[FLAG_Z] <= ALUFlags[FLAG_Z];
      end
      if (write_cv) begin
        FlagsE[FLAG_C] <= ALUFlags[FLAG_C];
        FlagsE[FLAG_V] <= ALUFlags[FLAG_V];
      end
    end
  end

  // Side-effecting controls are squashed on a failed condition; data fields
  // travel regardless since nothing downstream consumes them without a control.
  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      PCSrcM     <= 1'b0;
      RegWriteM  <= 1'b0;
      MemToRegM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      WA3M       <= 5'd0;
      CtrlM      <= 7'd0;
    end else begin
      PCSrcM     <= PCSrcGatedE;
      RegWriteM  <= RegWriteE & CondExE;
      MemToRegM  <= MemToRegE;
      MemWriteM  <= MemWriteE & CondExE;
      ALUResultM <= ALUResultE;
      WriteDataM <= WriteDataE;
      WA3M       <= WA3E;
      CtrlM      <= CtrlE;
    end
  end

endmodule

// File: tb/tb_execute_cond_em.sv
// Self-checking bench for execute_cond_em: directed plan steps plus randomized
// instructions compared against a flag/condition reference model.
module tb_execute_cond_em;

  localparam int SIZE = 32;

  logic            CLK;
  logic            CLR;
  logic            PCSrcE, RegWriteE, MemToRegE, MemWriteE, BranchE;
  logic [1:0]      FlagWriteE;
  logic [3:0]      CondE;
  logic [3:0]      ALUFlags;
  logic [SIZE-1:0] ALUResultE, WriteDataE;
  logic [4:0]      WA3E;
  logic [6:0]      CtrlE;
  logic            CondExE, PCSrcGatedE;
  logic [3:0]      FlagsE;
  logic            PCSrcM, RegWriteM, MemToRegM, MemWriteM;
  logic [SIZE-1:0] ALUResultM, WriteDataM;
  logic [4:0]      WA3M;
  logic [6:0]      CtrlM;

  int passCount;
  int checkCount;
  int failCount;
  logic [3:0] modelFlags;

  execute_cond_em #(.SIZE(SIZE)) dut (
    .CLK(CLK), .CLR(CLR),
    .PCSrcE(PCSrcE), .RegWriteE(RegWriteE), .MemToRegE(MemToRegE),
    .MemWriteE(MemWriteE), .BranchE(BranchE), .FlagWriteE(FlagWriteE),
    .CondE(CondE), .ALUFlags(ALUFlags), .ALUResultE(ALUResultE),
    .WriteDataE(WriteDataE), .WA3E(WA3E), .CtrlE(CtrlE),
    .CondExE(CondExE), .PCSrcGatedE(PCSrcGatedE), .FlagsE(FlagsE),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemToRegM(MemToRegM),
    .MemWriteM(MemWriteM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
    .WA3M(WA3M), .CtrlM(CtrlM)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Reference: whether an instruction with this condition runs, given N,Z,C,V.
  function automatic logic condPasses(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    logic signedGe;
    n = f[3]; z = f[2]; c = f[1]; v = f[0];
    signedGe = (n == v);
    case (cond)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return signedGe;
      4'd11: return !signedGe;
      4'd12: return !z && signedGe;
      4'd13: return z || !signedGe;
      default: return 1'b1;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One instruction: drive after the rising edge, check combinational outputs
  // mid-cycle, then check the M stage and flags just after the falling edge.
  task automatic applyStimulus(input logic pcs, input logic rw, input logic m2r,
                               input logic mw, input logic br, input logic [1:0] fw,
                               input logic [3:0] cond, input logic [3:0] af);
    logic [31:0] res, wd, rnd;
    logic        expCond;
    res = $urandom();
    wd  = $urandom();
    rnd = $urandom();
    @(posedge CLK);
    PCSrcE = pcs; RegWriteE = rw; MemToRegE = m2r; MemWriteE = mw; BranchE = br;
    FlagWriteE = fw; CondE = cond; ALUFlags = af;
    ALUResultE = res; WriteDataE = wd; WA3E = rnd[4:0]; CtrlE = rnd[11:5];
    #1;
    expCond = condPasses(cond, modelFlags);
    checkOutput("CondExE", 32'(CondExE), 32'(expCond));
    checkOutput("PCSrcGatedE", 32'(PCSrcGatedE), 32'((pcs | br) & expCond));
    checkOutput("FlagsE_before", 32'(FlagsE), 32'(modelFlags));
    if (expCond && fw[1]) modelFlags[3:2] = af[3:2];
    if (expCond && fw[0]) modelFlags[1:0] = af[1:0];
    @(negedge CLK);
    #1;
    checkOutput("PCSrcM", 32'(PCSrcM), 32'((pcs | br) & expCond));
    checkOutput("RegWriteM", 32'(RegWriteM), 32'(rw & expCond));
    checkOutput("MemToRegM", 32'(MemToRegM), 32'(m2r));
    checkOutput("MemWriteM", 32'(MemWriteM), 32'(mw & expCond));
    checkOutput("ALUResultM", ALUResultM, res);
    checkOutput("WriteDataM", WriteDataM, wd);
    checkOutput("WA3M", 32'(WA3M), 32'(rnd[4:0]));
    checkOutput("CtrlM", 32'(CtrlM), 32'(rnd[11:5]));
    checkOutput("FlagsE_after", 32'(FlagsE), 32'(modelFlags));
  endtask

  task automatic setFlags(input logic [3:0] f);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 4'b1110, f);
  endtask

  initial begin
    logic [31:0] rnd;
    logic [31:0] midRes;
    passCount  = 0;
    checkCount = 0;
    failCount  = 0;
    modelFlags = 4'b0000;
    CLR = 1'b1;
    PCSrcE = 0; RegWriteE = 0; MemToRegE = 0; MemWriteE = 0; BranchE = 0;
    FlagWriteE = 2'b00; CondE = 4'b1110; ALUFlags = 4'b0000;
    ALUResultE = '0; WriteDataE = '0; WA3E = '0; CtrlE = '0;

    #2;
    checkOutput("reset_FlagsE", 32'(FlagsE), 32'd0);
    checkOutput("reset_RegWriteM", 32'(RegWriteM), 32'd0);
    checkOutput("reset_ALUResultM", ALUResultM, 32'd0);
    @(posedge CLK);
    #1 CLR = 1'b0;

    // Flag set then use: SUB sets Z, then EQ passes.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11, 4'b1110, 4'b0100);
    checkOutput("plan_flags_0100", 32'(FlagsE), 32'h4);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b0000, 4'b0000);
    checkOutput("plan_eq_RegWriteM", 32'(RegWriteM), 32'd1);

    // Mid-cycle asynchronous reset with RegWriteE high, then capture on release.
    @(posedge CLK);
    midRes = $urandom();
    RegWriteE = 1'b1; CondE = 4'b1110; FlagWriteE = 2'b00; ALUResultE = midRes;
    MemWriteE = 1'b1; WA3E = 5'd9; CtrlE = 7'h55;
    #2 CLR = 1'b1;
    #1;
    checkOutput("midreset_FlagsE", 32'(FlagsE), 32'd0);
    checkOutput("midreset_RegWriteM", 32'(RegWriteM), 32'd0);
    checkOutput("midreset_ALUResultM", ALUResultM, 32'd0);
    checkOutput("midreset_WA3M", 32'(WA3M), 32'd0);
    modelFlags = 4'b0000;
    #1 CLR = 1'b0;
    @(negedge CLK);
    #1;
    checkOutput("release_RegWriteM", 32'(RegWriteM), 32'd1);
    checkOutput("release_MemWriteM", 32'(MemWriteM), 32'd1);
    checkOutput("release_ALUResultM", ALUResultM, midRes);
    checkOutput("release_WA3M", 32'(WA3M), 32'd9);
    checkOutput("release_CtrlM", 32'(CtrlM), 32'h55);

    // Failed condition squashes writes and flag update.
    setFlags(4'b0000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b11, 4'b0000, 4'b1111);
    checkOutput("squash_MemWriteM", 32'(MemWriteM), 32'd0);
    checkOutput("squash_FlagsE", 32'(FlagsE), 32'd0);

    // Partial flag write updates only N,Z.
    setFlags(4'b1111);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 4'b1110, 4'b0000);
    checkOutput("partial_FlagsE", 32'(FlagsE), 32'h3);

    // Signed comparisons.
    setFlags(4'b1000);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1100, 4'b0000);
    checkOutput("gt_RegWriteM", 32'(RegWriteM), 32'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1011, 4'b0000);
    checkOutput("lt_RegWriteM", 32'(RegWriteM), 32'd1);
    setFlags(4'b1001);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 4'b1010, 4'b0000);
    checkOutput("ge_RegWriteM", 32'(RegWriteM), 32'd1);

    // Branch gating on NE.
    setFlags(4'b0100);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0001, 4'b0000);
    checkOutput("bne_taken_Z1", 32'(PCSrcM), 32'd0);
    setFlags(4'b0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 4'b0001, 4'b0000);
    checkOutput("bne_taken_Z0", 32'(PCSrcM), 32'd1);

    // Randomized instruction stream with occasional bubbles.
    for (int i = 0; i < 200; i++) begin
      rnd = $urandom();
      if (rnd[31:29] == 3'b000)
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, rnd[3:0], rnd[7:4]);
      else
        applyStimulus(rnd[8], rnd[9], rnd[10], rnd[11], rnd[12], rnd[14:13],
                      rnd[3:0], rnd[7:4]);
    end

    $display("[TB] %0d comparisons, %0d failing", checkCount, failCount);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/execute_cond_em.md
Name: execute_cond_em

Overview:
Execute-stage back half of the pipelined CPU. Consumes the control/data bundle leaving the decode-to-execute register plus the ALU result and ALU flags, and holds the architectural NZCV flags register. Evaluates each instruction's condition field and squashes side effects of failed conditions. Captures surviving results into the execute-to-memory pipeline register.

Parameters:
SIZE, 32, datapath width of ALU result and store data.

Ports:
CLK  input  1  pipeline clock; all state samples on falling edge (same edge as the other pipeline registers).
CLR  input  1  asynchronous, active-high reset; clears flags and every M-stage output.
PCSrcE  input  1  instruction writes PC.
RegWriteE  input  1  instruction writes register file.
MemToRegE  input  1  writeback selects memory data.
MemWriteE  input  1  instruction stores.
BranchE  input  1  instruction is a branch.
FlagWriteE  input  2  [1] update N,Z; [0] update C,V.
CondE  input  4  condition code.
ALUFlags  input  4  {N,Z,C,V} from the ALU for this instruction.
ALUResultE  input  SIZE  ALU result.
WriteDataE  input  SIZE  forwarded store data.
WA3E  input  5  destination register.
CtrlE  input  7  opaque extension control, passed through.
CondExE  output  1  combinational: condition passed.
PCSrcGatedE  output  1  combinational: (PCSrcE | BranchE) & CondExE; used by the hazard unit for flush.
FlagsE  output  4  current flags register {N,Z,C,V}.
PCSrcM, RegWriteM, MemToRegM, MemWriteM  output  1 each  registered, gated controls.
ALUResultM  output  SIZE  registered ALU result.
WriteDataM  output  SIZE  registered store data.
WA3M  output  5  registered destination.
CtrlM  output  7  registered CtrlE.

Behaviour:
- Reset: CLR high asynchronously forces FlagsE=4'b0 and all M-stage outputs to 0. Clears at once, mid-cycle included. Release takes effect at the next falling edge.
- Condition decode uses the flags register value, not ALUFlags:
  - 0000 EQ Z; 0001 NE ~Z; 0010 CS C; 0011 CC ~C.
  - 0100 MI N; 0101 PL ~N; 0110 VS V; 0111 VC ~V.
  - 1000 HI C&~Z; 1001 LS ~C|Z; 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 1.
- Gating: RegWriteM<=RegWriteE&CondExE; MemWriteM<=MemWriteE&CondExE; PCSrcM<=PCSrcGatedE.
- Ungated: MemToRegM, ALUResultM, WriteDataM, WA3M, CtrlM register unconditionally.
- Flags update at the falling edge:
  - N,Z <= ALUFlags[3:2] when FlagWriteE[1]&CondExE.
  - C,V <= ALUFlags[1:0] when FlagWriteE[0]&CondExE.
  - Otherwise the flags hold.
- Latency: one cycle E->M.
- A flag update is visible to the next instruction's CondExE one cycle later.
- Same-cycle flag write and condition test: the test sees the old flags.
- Failed condition with FlagWriteE set: no flag change.
- A bubble (all controls 0) passes through as a bubble; flags are untouched.

Decomposition:
- Shared package cpu_pkg holds:
  - cond_t enum of the 16 condition codes.
  - flag index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- Sub-module cond_check: purely combinational cond_t + flags -> CondExE.
- The EM register and flags register stay in execute_cond_em.

Test Plan:
- Reset: CLR=1 mid-cycle with RegWriteE=1 -> all M outputs 0 and FlagsE=0 immediately. First falling edge after release captures the inputs.
- Flag set then use: cycle 1 SUB with FlagWriteE=2'b11, CondE=1110, ALUFlags=0100 -> FlagsE=0100. Cycle 2 CondE=0000 (EQ), RegWriteE=1 -> CondExE=1, RegWriteM=1.
- Failed condition squash: FlagsE=0000, CondE=0000, MemWriteE=1, RegWriteE=1, FlagWriteE=2'b11, ALUFlags=1111 -> MemWriteM=0, RegWriteM=0, FlagsE stays 0000. ALUResultM still equals ALUResultE.
- Partial flag write: FlagsE=1111, FlagWriteE=2'b10, ALUFlags=0000, AL -> FlagsE=0011.
- Signed compare: FlagsE=1000 (N=1,V=0) -> GT gives CondExE=0, LT gives 1. FlagsE=1001 -> GE gives 1.
- Branch gating: BranchE=1, CondE=0001 (NE), Z=1 -> PCSrcGatedE=0, PCSrcM=0. With Z=0 -> both 1.
